pipe_hazard_ctrl: RTL

Pipeline hazard and flush controller for the RNBIP-2 two-stage control pipeline. Sits between the instruction fetch/decode stage and the opcode/flag latch that feeds the control decoder. Each cycle it decides whether the front end advances, holds, or injects a NOP bubble (opcode 0x00) into the execute-stage opcode latch. It covers three cases: taken control transfers in execute, load-use register hazards, and external memory wait.

---
 rtl/rnbip_pkg.sv | 44 ++++
 rtl/hazard_classify.sv | 31 +++
 rtl/pipe_hazard_ctrl.sv | 104 ++++++++++
 3 files changed

// File: rtl/rnbip_pkg.sv
// Shared opcode map, class ranges and controller state encoding for the
// RNBIP-2 control pipeline.
package rnbip_pkg;

  localparam logic [7:0] OP_NOP = 8'h00;

  // Unconditional taken transfers: JUD, JUA, CUD, CUA, RTU
  localparam logic [7:0] TT_UNC_LO = 8'h03;
  localparam logic [7:0] TT_UNC_HI = 8'h07;

  // Flag-qualified transfers: JCD, JCA, CCD+CCA, RTC
  localparam logic [7:0] TT_JCD_LO = 8'h08;
  localparam logic [7:0] TT_JCD_HI = 8'h0F;
  localparam logic [7:0] TT_JCA_LO = 8'h28;
  localparam logic [7:0] TT_JCA_HI = 8'h2F;
  localparam logic [7:0] TT_CC_LO  = 8'h30;
  localparam logic [7:0] TT_CC_HI  = 8'h3F;
  localparam logic [7:0] TT_RTC_LO = 8'h48;
  localparam logic [7:0] TT_RTC_HI = 8'h4F;

  // Register-writing memory ops: LDA rn, POP rn
  localparam logic [7:0] LU_PROD_LO = 8'h71;
  localparam logic [7:0] LU_PROD_HI = 8'h7F;

  // Consumers of rn: NOT, INC, DCR, STA+PSH, ALU block
  localparam logic [7:0] LU_NOT_LO = 8'h20;
  localparam logic [7:0] LU_NOT_HI = 8'h27;
  localparam logic [7:0] LU_INC_LO = 8'h40;
  localparam logic [7:0] LU_INC_HI = 8'h47;
  localparam logic [7:0] LU_DCR_LO = 8'h50;
  localparam logic [7:0] LU_DCR_HI = 8'h57;
  localparam logic [7:0] LU_STP_LO = 8'h61;
  localparam logic [7:0] LU_STP_HI = 8'h6F;
  localparam logic [7:0] LU_ALU_LO = 8'h80;
  localparam logic [7:0] LU_ALU_HI = 8'hEF;

  typedef enum logic [1:0] {ST_RUN, ST_FLUSH, ST_WAIT} state_t;

  function automatic logic in_rng(input logic [7:0] op, input logic [7:0] lo,
                                  input logic [7:0] hi);
    return (op >= lo) && (op <= hi);
  endfunction

endpackage

// File: rtl/hazard_classify.sv
// Combinational decode of the execute/decode opcode pair into taken-transfer
// and load-use hazard hits.
module hazard_classify
  import rnbip_pkg::*;
(
  input  logic [7:0] id_opcode,
  input  logic [7:0] ex_opcode,
  input  logic       ex_flag,
  output logic       tt_hit,
  output logic       lu_hit
);

  logic w_tt_unc, w_tt_cond, w_lu_prod, w_lu_cons;

  assign w_tt_unc  = in_rng(ex_opcode, TT_UNC_LO, TT_UNC_HI);
  assign w_tt_cond = in_rng(ex_opcode, TT_JCD_LO, TT_JCD_HI) |
                     in_rng(ex_opcode, TT_JCA_LO, TT_JCA_HI) |
                     in_rng(ex_opcode, TT_CC_LO,  TT_CC_HI)  |
                     in_rng(ex_opcode, TT_RTC_LO, TT_RTC_HI);
  assign tt_hit    = w_tt_unc | (w_tt_cond & ex_flag);

  assign w_lu_prod = in_rng(ex_opcode, LU_PROD_LO, LU_PROD_HI);
  assign w_lu_cons = in_rng(id_opcode, LU_NOT_LO, LU_NOT_HI) |
                     in_rng(id_opcode, LU_INC_LO, LU_INC_HI) |
                     in_rng(id_opcode, LU_DCR_LO, LU_DCR_HI) |
                     in_rng(id_opcode, LU_STP_LO, LU_STP_HI) |
                     in_rng(id_opcode, LU_ALU_LO, LU_ALU_HI);
  // rn is encoded in the low three opcode bits for both producer and consumer
  assign lu_hit    = w_lu_prod & w_lu_cons & (id_opcode[2:0] == ex_opcode[2:0]);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Front-end advance/hold/bubble controller: flushes on taken transfers,
// stalls one cycle on load-use, and holds through external memory waits.
module pipe_hazard_ctrl
  import rnbip_pkg::*;
#(
  parameter int FLUSH_DEPTH = 2,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       id_opcode,
  input  logic [7:0]       ex_opcode,
  input  logic             ex_flag,
  input  logic             ext_hold,
  output logic             pc_hold,
  output logic             ifid_hold,
  output logic             ex_bubble,
  output logic             flush_active,
  output logic [CNT_W-1:0] perf_cnt
);

  localparam logic [1:0] FCNT_INIT = 2'(FLUSH_DEPTH - 1);

  state_t           r_state;
  logic [1:0]       r_fcnt;
  logic [CNT_W-1:0] r_perf;
  logic             w_tt, w_lu;

  hazard_classify u_cls (
    .id_opcode (id_opcode),
    .ex_opcode (ex_opcode),
    .ex_flag   (ex_flag),
    .tt_hit    (w_tt),
    .lu_hit    (w_lu)
  );

  // Gated by rst_n so reset forces quiet outputs whatever the inputs do
  always_comb begin
    pc_hold      = 1'b0;
    ifid_hold    = 1'b0;
    ex_bubble    = 1'b0;
    flush_active = 1'b0;
    if (rst_n) begin
      case (r_state)
        ST_RUN: begin
          if (w_tt) begin
            ex_bubble    = 1'b1;
            flush_active = 1'b1;
          end else if (w_lu) begin
            pc_hold   = 1'b1;
            ifid_hold = 1'b1;
            ex_bubble = 1'b1;
          end else if (ext_hold) begin
            pc_hold   = 1'b1;
            ifid_hold = 1'b1;
          end
        end
        ST_FLUSH: begin
          ex_bubble    = 1'b1;
          flush_active = 1'b1;
        end
        ST_WAIT: begin
          pc_hold   = ext_hold;
          ifid_hold = ext_hold;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_RUN;
      r_fcnt  <= 2'd0;
      r_perf  <= '0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (w_tt) begin
            if (FLUSH_DEPTH > 1) begin
              r_state <= ST_FLUSH;
              r_fcnt  <= FCNT_INIT;
            end
          end else if (!w_lu && ext_hold) begin
            r_state <= ST_WAIT;
          end
        end
        ST_FLUSH: begin
          r_fcnt <= r_fcnt - 2'd1;
          if (r_fcnt == 2'd1) r_state <= ST_RUN;
        end
        ST_WAIT: begin
          if (!ext_hold) r_state <= ST_RUN;
        end
        default: r_state <= ST_RUN;
      endcase
      if ((pc_hold || ex_bubble) && (r_perf != {CNT_W{1'b1}}))
        r_perf <= r_perf + CNT_W'(1);
    end
  end

  assign perf_cnt = r_perf;

endmodule
